// File: rtl/ifu_pkg.sv
// Shared types and constants for the AXI4-Lite instruction fetch unit.
package ifu_pkg;

  typedef enum logic [1:0] {
    ADDR  = 2'b00,
    DATA  = 2'b01,
    VALID = 2'b10
  } ifu_state_e;

  localparam logic [63:0] RESET_PC_DEFAULT = 64'h8000_0000;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // A 64-bit beat carries two instructions; address bit 2 picks the half.
  function automatic logic [31:0] select_word(input logic [63:0] data, input logic hi);
    return hi ? data[63:32] : data[31:0];
  endfunction

endpackage

// File: rtl/ifu_nextpc.sv
// Next-PC selection: exception entry, then exception return, then branch, else sequential.
module ifu_nextpc (
  input  logic [63:0] pc,
  input  logic        br_taken,
  input  logic [63:0] br_target,
  input  logic        ex,
  input  logic [63:0] ex_entry,
  input  logic        ex_ret,
  input  logic [63:0] epc,
  output logic [63:0] nextpc
);

  // NOTE: a default is assigned first so every path drives nextpc and no latch is inferred.
  always_comb begin
    nextpc = pc + 64'd4;
    if (ex)            nextpc = ex_entry;
    else if (ex_ret)   nextpc = epc;
    else if (br_taken) nextpc = br_target;
  end

endmodule

// File: rtl/ifu_axi.sv
// Instruction fetch unit: one outstanding AXI4-Lite read per instruction,
// ADDR -> DATA -> VALID, with redirect applied on the decode handshake.
module ifu_axi
  import ifu_pkg::*;
#(
  parameter logic [63:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  output logic [63:0] araddr,
  output logic        arvalid,
  input  logic        arready,
  input  logic [63:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rvalid,
  output logic        rready,
  output logic [31:0] inst,
  output logic [63:0] pc,
  output logic [63:0] nextpc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic        fetch_fault,
  output logic        misalign,
  input  logic        br_taken,
  input  logic [63:0] br_target,
  input  logic        ex,
  input  logic [63:0] ex_entry,
  input  logic        ex_ret,
  input  logic [63:0] epc
);

  ifu_state_e  state, state_nxt;
  logic [31:0] inst_q;
  logic        fault_q;
  logic        misalign_q;
  logic        pc_aligned;

  assign pc_aligned = (pc[1:0] == 2'b00);

  ifu_nextpc u_nextpc (
    .pc        (pc),
    .br_taken  (br_taken),
    .br_target (br_target),
    .ex        (ex),
    .ex_entry  (ex_entry),
    .ex_ret    (ex_ret),
    .epc       (epc),
    .nextpc    (nextpc)
  );

  always_comb begin
    state_nxt  = state;
    arvalid    = 1'b0;
    rready     = 1'b0;
    inst_valid = 1'b0;
    unique case (state)
      ADDR: begin
        // A misaligned PC never reaches the bus; it is reported straight to decode.
        if (!pc_aligned) begin
          state_nxt = VALID;
        end else begin
          arvalid = !rst;
          if (arvalid && arready) state_nxt = DATA;
        end
      end
      DATA: begin
        rready = 1'b1;
        if (rvalid) state_nxt = VALID;
      end
      VALID: begin
        inst_valid = 1'b1;
        if (inst_ready) state_nxt = ADDR;
      end
      default: state_nxt = ADDR;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ADDR;
      pc         <= RESET_PC;
      inst_q     <= 32'h0;
      fault_q    <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == ADDR && !pc_aligned) begin
        inst_q     <= 32'h0;
        fault_q    <= 1'b0;
        misalign_q <= 1'b1;
      end
      if (state == DATA && rvalid) begin
        misalign_q <= 1'b0;
        fault_q    <= (rresp != RESP_OKAY);
        inst_q     <= (rresp != RESP_OKAY) ? 32'h0 : select_word(rdata, pc[2]);
      end
      if (state == VALID && inst_ready) pc <= nextpc;
    end
  end

  assign araddr      = pc;
  assign inst        = inst_q;
  assign fetch_fault = inst_valid && fault_q;
  assign misalign    = inst_valid && misalign_q;

endmodule

// File: doc/ifu_axi.md
IFU_AXI -- requirements
Module: ifu_axi

Interface
REQ-001 Parameter: RESET_PC, 64'h8000_0000, PC loaded by reset.
REQ-002 Clock and reset: one clock; reset is synchronous and active-high. Ports are named clk and rst, as elsewhere in the codebase.
REQ-003 Port: clk  in  1  core clock; all state changes on rising edge.
REQ-004 Port: rst  in  1  synchronous active-high reset.
REQ-005 Port: araddr  out  64  read address (equals pc).
REQ-006 Port: arvalid / arready  out / in  1 / 1  AXI4-Lite read-address handshake.
REQ-007 Port: rdata  in  64  read data; word at araddr[2].
REQ-008 Port: rresp  in  2  read response; nonzero = access fault.
REQ-009 Port: rvalid / rready  in / out  1 / 1  read-data handshake.
REQ-010 Port: inst  out  32  fetched instruction to decode.
REQ-011 Port: pc  out  64  address of inst.
REQ-012 Port: nextpc  out  64  PC selected for the next fetch (combinational).
REQ-013 Port: inst_valid / inst_ready  out / in  1 / 1  decode handshake.
REQ-014 Port: fetch_fault / misalign  out  1 / 1  qualified by inst_valid.
REQ-015 Port: br_taken, br_target[63:0], ex, ex_entry[63:0], ex_ret, epc[63:0]  in  redirect inputs, sampled only on a decode handshake.

Function
REQ-016 States: ADDR (arvalid=1), DATA (rready=1), VALID (inst_valid=1). No other outputs are asserted in any state.
REQ-017 ADDR -> DATA on arvalid&&arready. DATA -> VALID on rvalid&&rready. VALID -> ADDR on inst_valid&&inst_ready.
REQ-018 araddr, arvalid and pc stay stable from arvalid assertion until the handshake completes (AXI rule).
REQ-019 In DATA, the block captures inst = rdata[63:32] if pc[2]=1, else rdata[31:0]; fetch_fault = (rresp!=0).
REQ-020 inst, fetch_fault and misalign stay stable throughout VALID until inst_ready.
REQ-021 nextpc priority: ex ? ex_entry : ex_ret ? epc : br_taken ? br_target : pc+4 (64-bit wrap).
REQ-022 On the decode handshake, pc <= nextpc; the new fetch's arvalid is asserted in the following cycle. Minimum fetch latency: 3 cycles per instruction with zero-wait slave.
REQ-023 If pc[1:0]!=0 in ADDR, no AR is issued: go directly to VALID with misalign=1, inst=32'h0, fetch_fault=0.
REQ-024 On fetch_fault, inst=32'h0; pc still advances per REQ-021 at handshake (decode raises the trap via ex).
REQ-025 arready and rvalid arriving outside ADDR/DATA respectively are ignored; the block has exactly one outstanding read.
REQ-026 inst_ready held high from cycle 0 must not shorten any state.

Reset
REQ-027 While rst=1 (sampled at the edge): state=ADDR, pc=RESET_PC, arvalid=0, rready=0, inst_valid=0, inst=0, fetch_fault=0, misalign=0. arvalid rises in the first cycle after rst deasserts.
REQ-028 Reset mid-transaction abandons the outstanding read without waiting for a response; the memory slave shares rst.

Structure
REQ-029 A shared package ifu_pkg holds the state enum (ADDR/DATA/VALID), RESET_PC default, and AXI resp constants (OKAY=2'b00).
REQ-030 The nextpc priority mux is a separate combinational sub-module, ifu_nextpc.

Verification
REQ-031 Reset release, zero-wait slave returning 64'h0000_0013_0000_0093 at 0x8000_0000 -> inst=32'h0000_0093, pc=0x8000_0000, inst_valid in cycle 3; next araddr=0x8000_0004 selects 32'h0000_0013.
REQ-032 arready delayed 4 cycles, rvalid delayed 3 cycles -> araddr and arvalid stable throughout; inst_valid exactly 1 cycle after the R handshake.
REQ-033 inst_ready low for 5 cycles in VALID -> inst and pc unchanged; one handshake only, then next fetch.
REQ-034 Handshake with br_taken=1, br_target=0x8000_0100 and ex=1, ex_entry=0x8000_0200 -> next araddr=0x8000_0200. Repeat with ex=0 -> 0x8000_0100.
REQ-035 br_target=0x8000_0102 -> no arvalid; misalign=1, inst=0 and pc=0x8000_0102 on the next inst_valid. rresp=2'b10 -> fetch_fault=1, inst=0.
REQ-036 rst asserted while in DATA -> next cycle rready=0 and inst_valid=0; after release, fetch restarts at RESET_PC.
